// File: rtl/coherence_bus_arbiter.sv
// Snooping-bus arbiter and coherence transaction sequencer for NUM_CPUS MSI cache controllers.
// Build option: define ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module coherence_bus_arbiter #(
    parameter int unsigned NUM_CPUS = 4,
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned CPU_W    = 2
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [NUM_CPUS-1:0]        req,
    input  logic [2*NUM_CPUS-1:0]      req_op,
    input  logic [ADDR_W*NUM_CPUS-1:0] req_addr,
    input  logic [NUM_CPUS-1:0]        req_wb,
    input  logic                       mem_ack,
    input  logic [NUM_CPUS-1:0]        snoop_ack,
    output logic [NUM_CPUS-1:0]        grant,
    output logic [NUM_CPUS-1:0]        done,
    output logic                       bus_valid,
    output logic [1:0]                 bus_op,
    output logic [ADDR_W-1:0]          bus_addr,
    output logic [CPU_W-1:0]           bus_src,
    output logic                       wb_valid,
    output logic [ADDR_W-1:0]          wb_addr
);

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_INV  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WB    = 3'd1,
        S_BCAST = 3'd2,
        S_FILL  = 3'd3,
        S_ACK   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t state, state_next;

    logic [NUM_CPUS-1:0] eligible;
    logic                win_found;
    logic [CPU_W-1:0]    win_idx;

    logic [1:0]          op_q, op_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CPU_W-1:0]    src_q, src_d;
    logic [NUM_CPUS-1:0] coll_q, coll_d;
    logic [NUM_CPUS-1:0] src_onehot;
    logic                all_acked;

    logic [NUM_CPUS-1:0] grant_d, done_d;
    logic                bus_valid_d, wb_valid_d;
    logic [1:0]          bus_op_d;
    logic [ADDR_W-1:0]   bus_addr_d, wb_addr_d;
    logic [CPU_W-1:0]    bus_src_d;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < int'(NUM_CPUS); i++) begin
            eligible[i] = req[i] && (req_op[2*i +: 2] != OP_NONE);
        end
    end

`ifdef ARB_FIXED_PRIO_EN
    // Lowest eligible index wins; downward scan leaves the lowest hit last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = int'(NUM_CPUS) - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_found = 1'b1;
                win_idx   = CPU_W'(i);
            end
        end
    end
`else
    logic [CPU_W-1:0] rr_ptr;
    logic [CPU_W-1:0] cand;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rr_ptr <= CPU_W'(NUM_CPUS - 1);
        end else if (state == S_IDLE && win_found) begin
            rr_ptr <= win_idx;
        end
    end

    // Scan from farthest to nearest after the pointer so the nearest hit is kept.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned k = NUM_CPUS; k >= 1; k--) begin
            cand = CPU_W'((32'(rr_ptr) + k) % NUM_CPUS);
            if (eligible[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end
`endif

    // Source CPU never has to acknowledge its own broadcast.
    assign src_onehot = NUM_CPUS'(1) << src_q;
    assign all_acked  = &(coll_q | snoop_ack | src_onehot);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (win_found) state_next = req_wb[win_idx] ? S_WB : S_BCAST;
            S_WB:    if (mem_ack) state_next = S_BCAST;
            S_BCAST: state_next = (op_q == OP_INV) ? S_ACK : S_FILL;
            S_FILL:  if (mem_ack) state_next = S_ACK;
            S_ACK:   if (all_acked) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Next values of the registered outputs, keyed off the state being entered.
    always_comb begin
        grant_d     = grant;
        done_d      = '0;
        bus_valid_d = 1'b0;
        bus_op_d    = bus_op;
        bus_addr_d  = bus_addr;
        bus_src_d   = bus_src;
        wb_valid_d  = 1'b0;
        wb_addr_d   = wb_addr;
        op_d        = op_q;
        addr_d      = addr_q;
        src_d       = src_q;
        coll_d      = coll_q;
        case (state)
            S_IDLE: begin
                grant_d = '0;
                if (win_found) begin
                    grant_d = NUM_CPUS'(1) << win_idx;
                    op_d    = req_op[2*win_idx +: 2];
                    addr_d  = req_addr[ADDR_W*win_idx +: ADDR_W];
                    src_d   = win_idx;
                end
            end
            S_BCAST:       coll_d  = snoop_ack;
            S_FILL, S_ACK: coll_d  = coll_q | snoop_ack;
            S_DONE:        grant_d = '0;
            default:       ;
        endcase
        if (state_next == S_WB) begin
            wb_valid_d = 1'b1;
            wb_addr_d  = addr_d;
        end
        if (state_next == S_BCAST) begin
            bus_valid_d = 1'b1;
            bus_op_d    = op_d;
            bus_addr_d  = addr_d;
            bus_src_d   = src_d;
        end
        if (state_next == S_DONE) begin
            done_d = NUM_CPUS'(1) << src_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            grant     <= '0;
            done      <= '0;
            bus_valid <= 1'b0;
            bus_op    <= '0;
            bus_addr  <= '0;
            bus_src   <= '0;
            wb_valid  <= 1'b0;
            wb_addr   <= '0;
            op_q      <= '0;
            addr_q    <= '0;
            src_q     <= '0;
            coll_q    <= '0;
        end else begin
            grant     <= grant_d;
            done      <= done_d;
            bus_valid <= bus_valid_d;
            bus_op    <= bus_op_d;
            bus_addr  <= bus_addr_d;
            bus_src   <= bus_src_d;
            wb_valid  <= wb_valid_d;
            wb_addr   <= wb_addr_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            src_q     <= src_d;
            coll_q    <= coll_d;
        end
    end

endmodule

// File: tb/tb_coherence_bus_arbiter.sv
// Self-checking bench for coherence_bus_arbiter: directed vector table, reset-mid-writeback
// sequence, and randomized transactions checked against a transaction-timing model.
module tb_coherence_bus_arbiter;
    localparam int N   = 4;
    localparam int AW  = 8;
    localparam int CW  = 2;
    localparam int OW  = 2 * N;
    localparam int ADW = AW * N;
    localparam logic [7:0] NO_ACK = 8'hFF;

    logic           clock = 1'b0;
    logic           reset_n;
    logic [N-1:0]   req;
    logic [OW-1:0]  req_op;
    logic [ADW-1:0] req_addr;
    logic [N-1:0]   req_wb;
    logic           mem_ack;
    logic [N-1:0]   snoop_ack;
    logic [N-1:0]   grant;
    logic [N-1:0]   done;
    logic           bus_valid;
    logic [1:0]     bus_op;
    logic [AW-1:0]  bus_addr;
    logic [CW-1:0]  bus_src;
    logic           wb_valid;
    logic [AW-1:0]  wb_addr;

    always #5 clock = ~clock;

    coherence_bus_arbiter #(.NUM_CPUS(N), .ADDR_W(AW), .CPU_W(CW)) dut (
        .clock(clock), .reset_n(reset_n), .req(req), .req_op(req_op), .req_addr(req_addr),
        .req_wb(req_wb), .mem_ack(mem_ack), .snoop_ack(snoop_ack), .grant(grant), .done(done),
        .bus_valid(bus_valid), .bus_op(bus_op), .bus_addr(bus_addr), .bus_src(bus_src),
        .wb_valid(wb_valid), .wb_addr(wb_addr)
    );

    typedef struct {
        bit               pre_reset;
        logic [N-1:0]     req;
        logic [OW-1:0]    op;
        logic [ADW-1:0]   addr;
        logic [N-1:0]     wb;
        int               lw;      // WB cycles before mem_ack
        int               lf;      // FILL cycles before mem_ack
        logic [N-1:0][7:0] ackt;   // snoop_ack pulse offset from BCAST cycle
        int               exp_w;
        int               exp_d;   // done cycle, counted from the grant cycle
    } vec_t;

    int checks   = 0;
    int failures = 0;

    // Model state: last winner and the last broadcast values.
    int            last_w;
    logic [1:0]    m_bus_op;
    logic [AW-1:0] m_bus_addr;
    logic [CW-1:0] m_bus_src;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_grant"}, 32'(grant), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_bus_valid"}, 32'(bus_valid), 0);
        chk({tag, "_bus_op"}, 32'(bus_op), 0);
        chk({tag, "_bus_addr"}, 32'(bus_addr), 0);
        chk({tag, "_bus_src"}, 32'(bus_src), 0);
        chk({tag, "_wb_valid"}, 32'(wb_valid), 0);
        chk({tag, "_wb_addr"}, 32'(wb_addr), 0);
    endtask

    task automatic model_reset;
        last_w     = N - 1;
        m_bus_op   = '0;
        m_bus_addr = '0;
        m_bus_src  = '0;
    endtask

    task automatic do_reset;
        reset_n = 1'b0; req = '0; req_op = '0; req_addr = '0; req_wb = '0;
        mem_ack = 1'b0; snoop_ack = '0;
        tick;
        tick;
        check_zero("reset");
        reset_n = 1'b1;
        model_reset();
    endtask

    function automatic int model_winner(input logic [N-1:0] r, input logic [OW-1:0] op);
`ifdef ARB_FIXED_PRIO_EN
        for (int i = 0; i < N; i++)
            if (r[i] && op[2*i +: 2] != 2'b00) return i;
`else
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (last_w + k) % N;
            if (r[i] && op[2*i +: 2] != 2'b00) return i;
        end
`endif
        return -1;
    endfunction

    // Done lands one cycle after the later of ACK entry and the last non-source ack.
    function automatic int model_done(input bit lwb, input int lw, input int lf, input bit inv,
                                      input logic [N-1:0][7:0] ackt, input int w);
        int b, c;
        b = lwb ? lw + 1 : 0;
        c = inv ? b + 1 : b + 2 + lf;
        for (int j = 0; j < N; j++)
            if (j != w && b + int'(ackt[j]) > c) c = b + int'(ackt[j]);
        return c + 1;
    endfunction

    task automatic run_txn(input logic [N-1:0] r, input logic [OW-1:0] op,
                           input logic [ADW-1:0] ad, input logic [N-1:0] wb,
                           input int lw, input int lf, input logic [N-1:0][7:0] ackt,
                           input int exp_w, input int exp_d, input bit rnd);
        logic [N-1:0]  oh, sa;
        logic [1:0]    lop;
        logic [AW-1:0] la;
        bit            lwb, inv, ma;
        int            b;
        oh  = N'(1) << exp_w;
        lop = op[2*exp_w +: 2];
        la  = ad[AW*exp_w +: AW];
        lwb = wb[exp_w];
        inv = (lop == 2'b11);
        b   = lwb ? lw + 1 : 0;
        req = r; req_op = op; req_addr = ad; req_wb = wb; mem_ack = 1'b0; snoop_ack = '0;
        for (int k = 0; k <= exp_d + 1; k++) begin
            tick;
            chk($sformatf("grant@%0d", k), 32'(grant), (k <= exp_d) ? 32'(oh) : 0);
            chk($sformatf("done@%0d", k), 32'(done), (k == exp_d) ? 32'(oh) : 0);
            chk($sformatf("bus_valid@%0d", k), 32'(bus_valid), 32'(k == b));
            chk($sformatf("wb_valid@%0d", k), 32'(wb_valid), 32'(lwb && k <= lw));
            if (lwb && k <= lw) chk($sformatf("wb_addr@%0d", k), 32'(wb_addr), 32'(la));
            chk($sformatf("bus_op@%0d", k), 32'(bus_op), (k >= b) ? 32'(lop) : 32'(m_bus_op));
            chk($sformatf("bus_addr@%0d", k), 32'(bus_addr), (k >= b) ? 32'(la) : 32'(m_bus_addr));
            chk($sformatf("bus_src@%0d", k), 32'(bus_src), (k >= b) ? 32'(exp_w) : 32'(m_bus_src));
            if (k <= exp_d) begin
                if (lwb && k <= lw) ma = (k == lw);
                else if (!inv && k > b && k <= b + 1 + lf) ma = (k == b + 1 + lf);
                else ma = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
                mem_ack = ma;
                for (int j = 0; j < N; j++) begin
                    sa[j] = (ackt[j] != NO_ACK) && (k == b + int'(ackt[j]));
                    if (rnd && k < b) sa[j] = 1'($urandom_range(0, 1));
                end
                snoop_ack = sa;
                if (rnd) begin
                    req = N'($urandom); req_op = OW'($urandom);
                    req_addr = ADW'($urandom); req_wb = N'($urandom);
                end
            end else begin
                mem_ack = 1'b0;
                snoop_ack = '0;
            end
        end
`ifndef ARB_FIXED_PRIO_EN
        last_w = exp_w;
`endif
        m_bus_op = lop; m_bus_addr = la; m_bus_src = CW'(exp_w);
    endtask

    function automatic vec_t mk(input bit pr, input logic [N-1:0] r, input logic [OW-1:0] op,
                                input logic [ADW-1:0] ad, input logic [N-1:0] wb, input int lw,
                                input int lf, input logic [N-1:0][7:0] ackt, input int w, input int d);
        vec_t v;
        v.pre_reset = pr; v.req = r; v.op = op; v.addr = ad; v.wb = wb;
        v.lw = lw; v.lf = lf; v.ackt = ackt; v.exp_w = w; v.exp_d = d;
        return v;
    endfunction

    vec_t tbl [10];
    int   rr_w [5];

    initial begin
`ifdef ARB_FIXED_PRIO_EN
        rr_w = '{0, 0, 0, 0, 0};
`else
        rr_w = '{0, 1, 2, 3, 0};
`endif
        // CPU1 read miss, FILL mem_ack after 3 cycles, acks from 0/2/3.
        tbl[0] = mk(0, 4'b0010, 8'h04, 32'h0000_3C00, 4'b0000, 0, 3, {8'd0, 8'd2, NO_ACK, 8'd1}, 1, 6);
        // CPU2 write miss with writeback of 0x81.
        tbl[1] = mk(0, 4'b0100, 8'h20, 32'h0081_0000, 4'b0100, 2, 1, {8'd0, NO_ACK, 8'd0, 8'd0}, 2, 7);
        // CPU3 invalidate, mem_ack held low, acks only during BCAST.
        tbl[2] = mk(0, 4'b1000, 8'hC0, 32'h5500_0000, 4'b0000, 0, 0, {NO_ACK, 8'd0, 8'd0, 8'd0}, 3, 2);
        // CPU0 read miss, CPU2 ack 10 cycles after mem_ack.
        tbl[3] = mk(0, 4'b0001, 8'h01, 32'h0000_00A7, 4'b0000, 0, 0, {8'd0, 8'd11, 8'd0, NO_ACK}, 0, 12);
        // CPU0 requests with op 00 (and wb set): ignored, CPU1 wins without writeback.
        tbl[4] = mk(1, 4'b0011, 8'h04, 32'h0000_2211, 4'b0001, 0, 0, {8'd0, 8'd0, NO_ACK, 8'd0}, 1, 3);
        for (int i = 0; i < 5; i++)
            tbl[5+i] = mk(i == 0, 4'b1111, 8'hFF, 32'h4030_2010, 4'b0000, 0, 0,
                          {8'd0, 8'd0, 8'd0, 8'd0}, rr_w[i], 2);

        do_reset();
        for (int i = 0; i < 10; i++) begin
            if (tbl[i].pre_reset) do_reset();
            run_txn(tbl[i].req, tbl[i].op, tbl[i].addr, tbl[i].wb, tbl[i].lw, tbl[i].lf,
                    tbl[i].ackt, tbl[i].exp_w, tbl[i].exp_d, 1'b0);
        end

        // Reset while a writeback is outstanding.
        begin
            bit seen;
            do_reset();
            req = 4'b0100; req_op = 8'h20; req_addr = 32'h0081_0000; req_wb = 4'b0100;
            seen = 1'b0;
            for (int i = 0; i < 4; i++) begin
                tick;
                if (wb_valid) begin
                    seen = 1'b1;
                    break;
                end
            end
            chk("wb_valid_before_reset", 32'(seen), 1);
            chk("wb_addr_before_reset", 32'(wb_addr), 32'h81);
            reset_n = 1'b0;
            tick;
            check_zero("mid_wb_reset");
            reset_n = 1'b1;
            model_reset();
            run_txn(4'b1111, 8'h55, 32'h4433_2211, 4'b0100, 0, 1,
                    {8'd1, 8'd0, 8'd2, NO_ACK}, 0, 4, 1'b0);
        end

        // Randomized transactions against the timing model.
        for (int t = 0; t < 80; t++) begin
            logic [N-1:0]      r, wb;
            logic [OW-1:0]     op;
            logic [ADW-1:0]    ad;
            logic [N-1:0][7:0] ackt;
            int w, lw, lf, d;
            r  = N'($urandom_range(1, (1 << N) - 1));
            ad = ADW'($urandom);
            wb = N'($urandom);
            for (int i = 0; i < N; i++)
                op[2*i +: 2] = ($urandom_range(0, 3) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            w = model_winner(r, op);
            if (w < 0 || $urandom_range(0, 4) == 0) begin
                req = r; req_op = (w < 0) ? op : '0; req_addr = ad; req_wb = wb;
                mem_ack = 1'($urandom_range(0, 1)); snoop_ack = N'($urandom);
                tick;
                chk("idle_grant", 32'(grant), 0);
                chk("idle_done", 32'(done), 0);
                chk("idle_bus_valid", 32'(bus_valid), 0);
                chk("idle_wb_valid", 32'(wb_valid), 0);
                chk("idle_bus_addr", 32'(bus_addr), 32'(m_bus_addr));
            end
            if (w >= 0) begin
                lw = $urandom_range(0, 3);
                lf = $urandom_range(0, 3);
                for (int j = 0; j < N; j++)
                    ackt[j] = (j == w) ? ($urandom_range(0, 1) ? NO_ACK : 8'($urandom_range(0, 6)))
                                       : 8'($urandom_range(0, lf + 5));
                d = model_done(wb[w], lw, lf, op[2*w +: 2] == 2'b11, ackt, w);
                run_txn(r, op, ad, wb, lw, lf, ackt, w, d, 1'b1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
